// File: rtl/nv_blkbox_pkg.sv
// Shared types and sizing helpers for the blackbox tie-off source chain.
// Provides the controller state encoding and byte-lane arithmetic.
package nv_blkbox_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD        = 3'd1,
        ST_DRAIN       = 3'd2,
        ST_FULL        = 3'd3,
        ST_COMMIT_WAIT = 3'd4
    } src_state_e;

    function automatic int nbytes_f(input int width);
        return width / LANE_W;
    endfunction

    // One extra bit so the counter can hold NBYTES itself without wrapping.
    function automatic int cnt_w_f(input int nbytes);
        return $clog2(nbytes) + 1;
    endfunction

endpackage

// File: rtl/nv_blkbox_src_shreg.sv
// Byte-lane shadow register: one lane is written per enabled cycle.
// Holds the staged tie-off value until the controller commits it.
module nv_blkbox_src_shreg
    import nv_blkbox_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] lane_idx,
    input  logic [7:0]       wr_data,
    output logic [WIDTH-1:0] shadow
);

    localparam int NB = nbytes_f(WIDTH);

    logic [WIDTH-1:0] shadow_r;

    // Lane write into the shadow register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_en && (lane_idx == IDX_W'(i))) begin
                    shadow_r[i*LANE_W +: LANE_W] <= wr_data;
                end
            end
        end
    end

    assign shadow = shadow_r;

endmodule

// File: rtl/nv_blkbox_src_chain.sv
// Programmable tie-off source: byte-serial load into a shadow register,
// then an explicit (optionally freeze-deferred) commit onto src_out.
module nv_blkbox_src_chain
    import nv_blkbox_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    input  logic             commit_req,
    input  logic             freeze,
    input  logic             err_clr,
    output logic [WIDTH-1:0] src_out,
    output logic             src_vld,
    output logic             ld_err,
    output logic             busy
);

    localparam int NBYTES = nbytes_f(WIDTH);
    localparam int CNT_W  = cnt_w_f(NBYTES);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NBYTES - 1);

    src_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] byte_cnt_r, byte_cnt_nxt_s;
    logic [WIDTH-1:0] src_out_r;
    logic             src_vld_r;
    logic             ld_err_r;
    logic [WIDTH-1:0] shadow_s;
    logic             ld_ready_s;
    logic             xfer_s;
    logic             wr_en_s;
    logic [CNT_W-1:0] lane_s;
    logic             err_set_s;
    logic             commit_s;

    assign ld_ready_s = (state_r == ST_IDLE) || (state_r == ST_LOAD) || (state_r == ST_DRAIN);
    assign xfer_s     = ld_valid && ld_ready_s;

    nv_blkbox_src_shreg #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_shreg (
        .clk      (nvdla_core_clk),
        .rst_n    (nvdla_core_rstn),
        .wr_en    (wr_en_s),
        .lane_idx (lane_s),
        .wr_data  (ld_data),
        .shadow   (shadow_s)
    );

    // Next-state, lane write, framing-error and commit decode
    always_comb begin
        state_nxt_s    = state_r;
        byte_cnt_nxt_s = byte_cnt_r;
        wr_en_s        = 1'b0;
        lane_s         = byte_cnt_r;
        err_set_s      = 1'b0;
        commit_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                lane_s = {CNT_W{1'b0}};
                if (xfer_s) begin
                    wr_en_s        = 1'b1;
                    byte_cnt_nxt_s = CNT_W'(1);
                    if (ld_last) begin
                        if (NBYTES == 1) begin
                            state_nxt_s = ST_FULL;
                        end else begin
                            err_set_s      = 1'b1;
                            state_nxt_s    = ST_IDLE;
                            byte_cnt_nxt_s = {CNT_W{1'b0}};
                        end
                    end else if (NBYTES == 1) begin
                        // Single-lane load already complete: extra bytes overrun.
                        err_set_s   = 1'b1;
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    wr_en_s        = 1'b1;
                    byte_cnt_nxt_s = byte_cnt_r + CNT_W'(1);
                    if (byte_cnt_r == LAST_LANE) begin
                        if (ld_last) begin
                            state_nxt_s = ST_FULL;
                        end else begin
                            err_set_s   = 1'b1;
                            state_nxt_s = ST_DRAIN;
                        end
                    end else if (ld_last) begin
                        err_set_s      = 1'b1;
                        state_nxt_s    = ST_IDLE;
                        byte_cnt_nxt_s = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && ld_last) begin
                    state_nxt_s    = ST_IDLE;
                    byte_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_FULL: begin
                if (commit_req && !freeze) begin
                    commit_s       = 1'b1;
                    state_nxt_s    = ST_IDLE;
                    byte_cnt_nxt_s = {CNT_W{1'b0}};
                end else if (commit_req) begin
                    state_nxt_s = ST_COMMIT_WAIT;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_COMMIT_WAIT: begin
                if (!freeze) begin
                    commit_s       = 1'b1;
                    state_nxt_s    = ST_IDLE;
                    byte_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_COMMIT_WAIT;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                byte_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Controller state and byte counter
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
        end
    end

    // Committed output value and valid flag
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            src_out_r <= RESET_VAL;
            src_vld_r <= 1'b0;
        end else if (commit_s) begin
            src_out_r <= shadow_s;
            src_vld_r <= 1'b1;
        end else begin
            src_out_r <= src_out_r;
            src_vld_r <= src_vld_r;
        end
    end

    // Sticky framing error; a new error outranks a simultaneous clear
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ld_err_r <= 1'b0;
        end else if (err_set_s) begin
            ld_err_r <= 1'b1;
        end else if (err_clr) begin
            ld_err_r <= 1'b0;
        end else begin
            ld_err_r <= ld_err_r;
        end
    end

    assign ld_ready = ld_ready_s;
    assign busy     = (state_r != ST_IDLE);
    assign src_out  = src_out_r;
    assign src_vld  = src_vld_r;
    assign ld_err   = ld_err_r;

endmodule

// File: tb/tb_nv_blkbox_src_chain.sv
// Directed self-checking bench for nv_blkbox_src_chain at WIDTH=32.
module tb_nv_blkbox_src_chain;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rstn;
    logic             ld_valid;
    logic             ld_ready;
    logic [7:0]       ld_data;
    logic             ld_last;
    logic             commit_req;
    logic             freeze;
    logic             err_clr;
    logic [WIDTH-1:0] src_out;
    logic             src_vld;
    logic             ld_err;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    nv_blkbox_src_chain #(
        .WIDTH     (WIDTH),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_data         (ld_data),
        .ld_last         (ld_last),
        .commit_req      (commit_req),
        .freeze          (freeze),
        .err_clr         (err_clr),
        .src_out         (src_out),
        .src_vld         (src_vld),
        .ld_err          (ld_err),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = l;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = 8'h00;
    endtask

    initial begin
        rstn       = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = 8'h00;
        ld_last    = 1'b0;
        commit_req = 1'b0;
        freeze     = 1'b0;
        err_clr    = 1'b0;
        #2;
        chk("rst_src_out", src_out, 32'h0);
        chk("rst_src_vld", {31'd0, src_vld}, 32'd0);
        chk("rst_ld_err", {31'd0, ld_err}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        rstn = 1'b1;
        step();

        // Normal 4-byte load and immediate commit
        send(8'h11, 1'b0);
        chk("t1_busy_load", {31'd0, busy}, 32'd1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        chk("t1_full_ready", {31'd0, ld_ready}, 32'd0);
        chk("t1_full_busy", {31'd0, busy}, 32'd1);
        chk("t1_pre_commit_out", src_out, 32'h0);
        chk("t1_pre_commit_vld", {31'd0, src_vld}, 32'd0);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("t1_src_out", src_out, 32'h4433_2211);
        chk("t1_src_vld", {31'd0, src_vld}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_ld_err", {31'd0, ld_err}, 32'd0);
        chk("t1_ready", {31'd0, ld_ready}, 32'd1);

        // Short load
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        chk("t2_ld_err", {31'd0, ld_err}, 32'd1);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("t2_src_out", src_out, 32'h4433_2211);
        chk("t2_busy_after_commit", {31'd0, busy}, 32'd0);
        chk("t2_err_sticky", {31'd0, ld_err}, 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t2_err_cleared", {31'd0, ld_err}, 32'd0);

        // Long load: overrun then drain
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        chk("t3_ld_err", {31'd0, ld_err}, 32'd1);
        chk("t3_drain_ready", {31'd0, ld_ready}, 32'd1);
        chk("t3_drain_busy", {31'd0, busy}, 32'd1);
        send(8'h55, 1'b0);
        chk("t3_drain_ready2", {31'd0, ld_ready}, 32'd1);
        chk("t3_drain_busy2", {31'd0, busy}, 32'd1);
        send(8'h66, 1'b1);
        chk("t3_idle", {31'd0, busy}, 32'd0);
        chk("t3_src_out", src_out, 32'h4433_2211);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Freeze-deferred commit
        send(8'hEF, 1'b0);
        send(8'hBE, 1'b0);
        send(8'hAD, 1'b0);
        send(8'hDE, 1'b1);
        freeze     = 1'b1;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_hold_out_%0d", i), src_out, 32'h4433_2211);
            chk($sformatf("t4_hold_busy_%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("t4_hold_ready_%0d", i), {31'd0, ld_ready}, 32'd0);
            step();
        end
        freeze = 1'b0;
        step();
        chk("t4_src_out", src_out, 32'hDEAD_BEEF);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_ld_err", {31'd0, ld_err}, 32'd0);

        // Reset mid-load, then a fresh load
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        rstn = 1'b0;
        #1;
        chk("t5_rst_out", src_out, 32'h0);
        chk("t5_rst_vld", {31'd0, src_vld}, 32'd0);
        chk("t5_rst_ready", {31'd0, ld_ready}, 32'd1);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        step();
        rstn = 1'b1;
        step();
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b1);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("t5_src_out", src_out, 32'h4030_2010);
        chk("t5_src_vld", {31'd0, src_vld}, 32'd1);

        // Error beats a simultaneous clear
        send(8'hAA, 1'b0);
        err_clr = 1'b1;
        send(8'hBB, 1'b1);
        chk("t6_err_wins", {31'd0, ld_err}, 32'd1);
        step();
        err_clr = 1'b0;
        chk("t6_err_cleared", {31'd0, ld_err}, 32'd0);
        chk("t6_src_out", src_out, 32'h4030_2010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nv_blkbox_src_chain.md
Name: nv_blkbox_src_chain

Overview:
- Programmable tie-off source: drives a WIDTH-bit constant onto spare/ECO nets, the driving counterpart of the blackbox sink tie-offs.
- After reset the output is a fixed constant. Software or a debug master can then replace it with a byte-serial load into a shadow register followed by an explicit commit.
- Sits beside spare-cell tie-offs in each NVDLA partition, on nvdla_core_clk.

Parameters:
- WIDTH, 32, output width; multiple of 8, range 8..256.
- RESET_VAL, {WIDTH{1'b0}}, src_out value after reset.
- NBYTES (localparam), WIDTH/8, bytes per complete load.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset; asynchronous assert, active-low
- ld_valid  in  1  load byte valid
- ld_ready  out  1  load byte ready
- ld_data  in  8  load byte; first accepted byte lands in bits [7:0]
- ld_last  in  1  marks final byte of a load
- commit_req  in  1  single-cycle commit request
- freeze  in  1  while high, a commit is deferred
- err_clr  in  1  clears ld_err
- src_out  out  WIDTH  driven constant
- src_vld  out  1  high once any commit has happened since reset
- ld_err  out  1  sticky framing error
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-low) while asserted:
  - state=IDLE, byte_cnt=0, shadow=0.
  - src_out=RESET_VAL, src_vld=0, ld_err=0, ld_ready=1, busy=0.
  - Reset mid-load or mid-wait discards everything; there is no partial commit.
- A transfer happens on a rising edge with ld_valid && ld_ready. Byte k is written to shadow[8k+7:8k].
- States:
  - IDLE: ld_ready=1. A transfer writes lane 0 and sets byte_cnt=1. If ld_last: go to FULL when NBYTES==1; otherwise set ld_err and stay in IDLE (short load). If not ld_last, go to LOAD.
  - LOAD: ld_ready=1. A transfer writes lane byte_cnt and increments byte_cnt.
    - ld_last before lane NBYTES-1: set ld_err, go to IDLE.
    - Lane NBYTES-1 with ld_last: go to FULL.
    - Lane NBYTES-1 without ld_last: set ld_err, go to DRAIN.
  - DRAIN: ld_ready=1. Bytes are accepted and discarded. The transfer with ld_last returns to IDLE.
  - FULL: ld_ready=0. commit_req with freeze=0 loads src_out<=shadow and sets src_vld=1 on the same edge, then goes to IDLE. commit_req with freeze=1 goes to COMMIT_WAIT.
  - COMMIT_WAIT: ld_ready=0. On the first edge where freeze=0: src_out<=shadow, src_vld=1, go to IDLE. commit_req in this state is ignored.
- commit_req in IDLE/LOAD/DRAIN is ignored: no error, src_out unchanged.
- src_out changes only on a commit edge. It is a registered output with no combinational path from inputs.
- ld_err is sticky. err_clr clears it next edge. If an error and err_clr occur on the same edge, the error wins (ld_err=1).
- byte_cnt is $clog2(NBYTES)+1 bits wide, resets to 0 on every return to IDLE, and never wraps inside LOAD.
- The shadow is not cleared on error; the next load overwrites it lane by lane.
- Latency: last byte accepted at edge N, so FULL holds from cycle N+1. Commit sampled at edge M gives new src_out visible from cycle M+1.

Decomposition:
- Shared package nv_blkbox_pkg:
  - state enum {IDLE, LOAD, DRAIN, FULL, COMMIT_WAIT}, binary-encoded, 3 bits.
  - byte-lane width constant (8).
  - NBYTES/counter-width helper functions.
- One natural sub-module: nv_blkbox_src_shreg, a byte-lane shadow register with lane index + write enable inputs and a WIDTH-bit output. The FSM, counter and error logic stay in the top.

Test Plan:
- WIDTH=32, bytes 0x11,0x22,0x33,0x44 (last on 4th), commit_req next cycle -> src_out=0x44332211, src_vld=1, busy=0, ld_err=0; src_out=0 before the commit edge.
- Short load: 0xAA, 0xBB (last on 2nd) -> ld_err=1, state IDLE, subsequent commit_req ignored, src_out unchanged.
- Long load: 4 bytes without last, then 0x55, 0x66 (last) -> ld_err=1, ld_ready=1 throughout DRAIN, back to IDLE, src_out unchanged.
- Freeze: complete load 0xDEADBEEF, freeze=1, commit_req -> src_out unchanged for 5 cycles, busy=1, ld_ready=0; drop freeze -> src_out=0xDEADBEEF the next cycle.
- Reset after 2 bytes accepted -> src_out=RESET_VAL, src_vld=0, ld_ready=1; a fresh 4-byte load plus commit yields the new value with no residue.
- err_clr asserted on the same edge as a short-load error -> ld_err stays 1; err_clr alone next cycle -> ld_err=0.
